// File: rtl/lock_sequencer_pkg.sv
// Shared types and defaults for the push-button code lock sequencer.
package lock_pkg;

    // FSM encoding; the values are fixed so the state can be decoded externally.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_PROGRAM = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    localparam logic DIGIT_ON  = 1'b1;
    localparam logic DIGIT_OFF = 1'b0;

    localparam int         DEF_CODE_LEN      = 5;
    localparam logic [4:0] DEF_CODE          = 5'b01011;
    localparam int         DEF_MAX_FAIL      = 3;
    localparam int         DEF_LOCKOUT_TICKS = 10;
    localparam int         DEF_OPEN_TICKS    = 5;
    localparam int         DEF_ENTRY_TIMEOUT = 4;

    // Width of the shared phase timer; wide enough for every tick count above.
    localparam int TIMER_W = 8;

    // A digit counts only when exactly one of the two pulses is present.
    function automatic logic digit_valid(input logic on_p, input logic off_p);
        return on_p ^ off_p;
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Pulse inputs and status outputs of the lock sequencer.
interface lock_sequencer_if;
    logic       tick;
    logic       onpulse;
    logic       offpulse;
    logic       prog_req;
    logic       unlocked;
    logic       prog_mode;
    logic       lockout;
    logic [2:0] fail_cnt;
    logic [2:0] digit_cnt;

    modport master (
        output tick, onpulse, offpulse, prog_req,
        input  unlocked, prog_mode, lockout, fail_cnt, digit_cnt
    );

    modport slave (
        input  tick, onpulse, offpulse, prog_req,
        output unlocked, prog_mode, lockout, fail_cnt, digit_cnt
    );
endinterface

// File: rtl/lock_sequencer_tick_timer.sv
// Down-counter paced by the divider tick; done fires on the tick that
// consumes the last count, so a phase loaded with K lasts K ticks.
module tick_timer
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] value_i,
    input  logic               tick_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q;

    // Load has priority over counting; the count parks at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TIMER_W'(1);
        end
    end

    assign done_o = tick_i && (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Code-entry sequencer: collects digits, checks them against a programmable
// code, counts failures, enforces lockout and auto-relocks.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN      = DEF_CODE_LEN,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = DEF_CODE,
    parameter int                  MAX_FAIL      = DEF_MAX_FAIL,
    parameter int                  LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
    parameter int                  OPEN_TICKS    = DEF_OPEN_TICKS,
    parameter int                  ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT
)(
    input  logic             clk,
    input  logic             reset,
    lock_sequencer_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] entry_sr_q, code_reg_q;
    logic [2:0]          digit_cnt_q, fail_cnt_q;
    logic                unlocked_q, prog_mode_q, lockout_q;

    logic                digit_v_s, digit_s, last_digit_s, code_match_s;
    logic [CODE_LEN-1:0] shifted_s;
    logic                timer_load_s, timer_done_s;
    logic [TIMER_W-1:0]  timer_val_s;

    assign digit_v_s    = digit_valid(bus.onpulse, bus.offpulse);
    assign digit_s      = bus.onpulse ? DIGIT_ON : DIGIT_OFF;
    assign last_digit_s = (digit_cnt_q == 3'(CODE_LEN - 1));
    assign code_match_s = (entry_sr_q == code_reg_q);
    assign shifted_s    = {entry_sr_q[CODE_LEN-2:0], digit_s};

    // Next-state decode; digits beat timeouts and prog_req beats relock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (digit_v_s) state_d = ST_ENTRY;
                else           state_d = ST_IDLE;
            end
            ST_ENTRY: begin
                if (digit_v_s)         state_d = last_digit_s ? ST_CHECK : ST_ENTRY;
                else if (timer_done_s) state_d = ST_IDLE;
                else                   state_d = ST_ENTRY;
            end
            ST_CHECK: begin
                if (code_match_s)                              state_d = ST_OPEN;
                else if ((fail_cnt_q + 3'd1) == 3'(MAX_FAIL))  state_d = ST_LOCKOUT;
                else                                           state_d = ST_IDLE;
            end
            ST_OPEN: begin
                if (bus.prog_req)      state_d = ST_PROGRAM;
                else if (timer_done_s) state_d = ST_IDLE;
                else                   state_d = ST_OPEN;
            end
            ST_PROGRAM: begin
                if (digit_v_s)         state_d = last_digit_s ? ST_IDLE : ST_PROGRAM;
                else if (timer_done_s) state_d = ST_IDLE;
                else                   state_d = ST_PROGRAM;
            end
            ST_LOCKOUT: begin
                if (timer_done_s) state_d = ST_IDLE;
                else              state_d = ST_LOCKOUT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer reload: on every state change and on each accepted entry digit.
    always_comb begin
        timer_val_s = '0;
        case (state_d)
            ST_ENTRY, ST_PROGRAM: timer_val_s = TIMER_W'(ENTRY_TIMEOUT);
            ST_OPEN:              timer_val_s = TIMER_W'(OPEN_TICKS);
            ST_LOCKOUT:           timer_val_s = TIMER_W'(LOCKOUT_TICKS);
            default:              timer_val_s = '0;
        endcase
        if ((state_d != state_q) ||
            (digit_v_s && ((state_q == ST_ENTRY) || (state_q == ST_PROGRAM)))) begin
            timer_load_s = 1'b1;
        end else begin
            timer_load_s = 1'b0;
        end
    end

    tick_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (timer_load_s),
        .value_i (timer_val_s),
        .tick_i  (bus.tick),
        .done_o  (timer_done_s)
    );

    // Sequencer state, shift register, counters and registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            entry_sr_q  <= '0;
            code_reg_q  <= DEFAULT_CODE;
            digit_cnt_q <= 3'd0;
            fail_cnt_q  <= 3'd0;
            unlocked_q  <= 1'b0;
            prog_mode_q <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            unlocked_q  <= (state_d == ST_OPEN);
            prog_mode_q <= (state_d == ST_PROGRAM);
            lockout_q   <= (state_d == ST_LOCKOUT);
            case (state_q)
                ST_IDLE: begin
                    if (digit_v_s) begin
                        entry_sr_q  <= shifted_s;
                        digit_cnt_q <= 3'd1;
                    end
                end
                ST_ENTRY: begin
                    if (digit_v_s) begin
                        entry_sr_q  <= shifted_s;
                        digit_cnt_q <= digit_cnt_q + 3'd1;
                    end else if (timer_done_s) begin
                        digit_cnt_q <= 3'd0;
                    end
                end
                ST_CHECK: begin
                    digit_cnt_q <= 3'd0;
                    if (code_match_s) fail_cnt_q <= 3'd0;
                    else              fail_cnt_q <= fail_cnt_q + 3'd1;
                end
                ST_OPEN: begin
                    if (bus.prog_req) digit_cnt_q <= 3'd0;
                end
                ST_PROGRAM: begin
                    if (digit_v_s) begin
                        entry_sr_q <= shifted_s;
                        if (last_digit_s) begin
                            code_reg_q  <= shifted_s;
                            digit_cnt_q <= 3'd0;
                        end else begin
                            digit_cnt_q <= digit_cnt_q + 3'd1;
                        end
                    end else if (timer_done_s) begin
                        digit_cnt_q <= 3'd0;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_done_s) fail_cnt_q <= 3'd0;
                end
                default: begin
                    digit_cnt_q <= 3'd0;
                end
            endcase
        end
    end

    assign bus.unlocked  = unlocked_q;
    assign bus.prog_mode = prog_mode_q;
    assign bus.lockout   = lockout_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: each checked stimulus cycle pushes the
// expected output word {unlocked, prog_mode, lockout, fail_cnt, digit_cnt},
// which is popped and compared once the DUT has reacted.
module tb_lock_sequencer;
    import lock_pkg::*;

    logic clk = 1'b0;
    logic reset;

    lock_sequencer_if bus();

    lock_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    wire [8:0] outs = {bus.unlocked, bus.prog_mode, bus.lockout, bus.fail_cnt, bus.digit_cnt};

    function automatic logic [8:0] exp_o(input logic u, input logic p, input logic l,
                                         input logic [2:0] f, input logic [2:0] d);
        return {u, p, l, f, d};
    endfunction

    task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got {u,p,l,f,d}=%b_%b_%b_%0d_%0d required %b_%b_%b_%0d_%0d",
                     tag, obs[8], obs[7], obs[6], obs[5:3], obs[2:0],
                     exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
        end
    endtask

    // One clock of stimulus; inputs are applied just after an edge.
    task automatic drive(input logic on, input logic off, input logic pr, input logic tk);
        bus.onpulse  = on;
        bus.offpulse = off;
        bus.prog_req = pr;
        bus.tick     = tk;
        @(posedge clk);
        #1;
        bus.onpulse  = 1'b0;
        bus.offpulse = 1'b0;
        bus.prog_req = 1'b0;
        bus.tick     = 1'b0;
    endtask

    task automatic sb_pop_check();
        exp_t item;
        item = sb_q.pop_front();
        check_val(item.tag, outs, item.val);
    endtask

    task automatic drive_chk(input logic on, input logic off, input logic pr, input logic tk,
                             input string tag, input logic [8:0] e);
        exp_t item;
        item.tag = tag;
        item.val = e;
        sb_q.push_back(item);
        drive(on, off, pr, tk);
        sb_pop_check();
    endtask

    task automatic enter_code(input logic [4:0] c);
        for (int i = 4; i >= 0; i--) drive(c[i], ~c[i], 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // From OPEN: four ticks keep it open, the fifth relocks.
    task automatic close_open(input string tag);
        ticks(4);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, tag, exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd0));
    endtask

    initial begin
        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.onpulse  = 1'b0;
        bus.offpulse = 1'b0;
        bus.prog_req = 1'b0;
        #3;
        check_val("reset_state", outs, 9'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Default code opens, digits ignored while open, relock after 5 ticks.
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, "t1_d1", exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd1));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive_chk(1'b1, 1'b0, 1'b0, 1'b0, "t1_d4", exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd4));
        drive_chk(1'b1, 1'b0, 1'b0, 1'b0, "t1_check", exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd5));
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t1_open", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));
        drive_chk(1'b1, 1'b0, 1'b0, 1'b0, "t1_open_dig", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));
        ticks(3);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, "t1_open_4t", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, "t1_relock", exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd0));

        // Three wrong codes lead to lockout; lockout ignores input for 10 ticks.
        enter_code(5'b11111);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t2_fail1", exp_o(1'b0, 1'b0, 1'b0, 3'd1, 3'd0));
        enter_code(5'b11111);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t2_fail2", exp_o(1'b0, 1'b0, 1'b0, 3'd2, 3'd0));
        enter_code(5'b11111);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t2_lock", exp_o(1'b0, 1'b0, 1'b1, 3'd3, 3'd0));
        drive_chk(1'b1, 1'b0, 1'b1, 1'b0, "t2_lock_ign", exp_o(1'b0, 1'b0, 1'b1, 3'd3, 3'd0));
        ticks(8);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, "t2_lock_9t", exp_o(1'b0, 1'b0, 1'b1, 3'd3, 3'd0));
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, "t2_unlock", exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd0));

        // Entry timeout keeps fail_cnt; a digit beats a coincident expiry.
        enter_code(5'b11111);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t4_fail1", exp_o(1'b0, 1'b0, 1'b0, 3'd1, 3'd0));
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, "t4_3t", exp_o(1'b0, 1'b0, 1'b0, 3'd1, 3'd2));
        drive_chk(1'b1, 1'b0, 1'b0, 1'b1, "t4_dig_wins", exp_o(1'b0, 1'b0, 1'b0, 3'd1, 3'd3));
        ticks(2);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, "t4_reload", exp_o(1'b0, 1'b0, 1'b0, 3'd1, 3'd3));
        drive_chk(1'b0, 1'b0, 1'b0, 1'b1, "t4_timeout", exp_o(1'b0, 1'b0, 1'b0, 3'd1, 3'd0));
        enter_code(5'b01011);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t4_open", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));
        close_open("t4_relock");

        // Both pulses in one cycle are ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive_chk(1'b1, 1'b1, 1'b0, 1'b0, "t5_both", exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd2));
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t5_open", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));
        close_open("t5_relock");

        // Reprogram to 11001; prog_req beats a coincident relock.
        enter_code(5'b01011);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t3_open", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));
        ticks(4);
        drive_chk(1'b0, 1'b0, 1'b1, 1'b1, "t3_prog_wins", exp_o(1'b0, 1'b1, 1'b0, 3'd0, 3'd0));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, "t3_prog_d4", exp_o(1'b0, 1'b1, 1'b0, 3'd0, 3'd4));
        drive_chk(1'b1, 1'b0, 1'b0, 1'b0, "t3_prog_done", exp_o(1'b0, 1'b0, 1'b0, 3'd0, 3'd0));
        enter_code(5'b01011);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t3_old_fails", exp_o(1'b0, 1'b0, 1'b0, 3'd1, 3'd0));
        enter_code(5'b11001);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t3_new_opens", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));

        // Asynchronous reset in the middle of programming restores the default code.
        drive_chk(1'b0, 1'b0, 1'b1, 1'b0, "t6_prog", exp_o(1'b0, 1'b1, 1'b0, 3'd0, 3'd0));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, "t6_prog_d3", exp_o(1'b0, 1'b1, 1'b0, 3'd0, 3'd3));
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_async_reset", outs, 9'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        enter_code(5'b01011);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, "t6_default_code", exp_o(1'b1, 1'b0, 1'b0, 3'd0, 3'd0));
        close_open("t6_relock");

        check_val("sb_drain", 9'(sb_q.size()), 9'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
